// File: rtl/ef_pkg.sv
// Shared definitions for the sample feeder: default sample width and slot
// period, plus the feeder state encoding.
package ef_pkg;

  // Samples are signed Q2.5 (1 sign, 2 integer, 5 fraction bits).
  localparam int unsigned EF_DI_W_DEF   = 8;
  // Clock cycles between output samples.
  localparam int unsigned EF_PERIOD_DEF = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } ef_state_t;

endpackage

// File: rtl/ef_sync_fifo.sv
// Single-clock FIFO with registered storage and a show-ahead head.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (empties the FIFO)
//   i_push       : write request; ignored while full
//   i_push_data  : word to write
//   i_pop        : read request; ignored while empty
//   o_head       : oldest stored word (valid while not empty)
//   o_level      : occupancy, 0..DEPTH
//   o_full       : level == DEPTH
//   o_empty      : level == 0
module ef_sync_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_push_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_head,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_level == FULL_LEVEL);
  assign o_empty = (r_level == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_level = r_level;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + 1'b1;
      end else if (!w_push && w_pop) begin
        r_level <= r_level - 1'b1;
      end
    end
  end

endmodule

// File: rtl/ef_sample_feeder.sv
// Paces buffered upstream samples into a filter at one sample every PERIOD
// clocks. Samples are queued in a FIFO; once PRIME_LVL samples are buffered
// the feeder runs a free slot counter and emits the FIFO head on every slot.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   enable    : run request; low returns to idle (FIFO and outputs retained)
//   in_valid  : upstream sample offered
//   in_data   : upstream sample (signed Q2.5, passed through unmodified)
//   in_ready  : FIFO not full; transfer on in_valid && in_ready
//   valid_o   : one-cycle strobe per emitted sample
//   data_o    : last emitted sample, held between strobes
//   level     : FIFO occupancy
//   sent_cnt  : samples emitted since reset (wraps)
//   underrun  : sticky, a slot found the FIFO empty
module ef_sample_feeder
  import ef_pkg::*;
#(
  parameter int unsigned DI_W      = EF_DI_W_DEF,
  parameter int unsigned PERIOD    = EF_PERIOD_DEF,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned PRIME_LVL = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   in_valid,
  input  logic [DI_W-1:0]        in_data,
  output logic                   in_ready,
  output logic                   valid_o,
  output logic [DI_W-1:0]        data_o,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            sent_cnt,
  output logic                   underrun
);

  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_LAST    = CW'(PERIOD - 1);
  localparam logic [LW-1:0] PRIME_LEVEL = LW'(PRIME_LVL);

  ef_state_t       r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_valid;
  logic [DI_W-1:0] r_data;
  logic [15:0]     r_sent;
  logic            r_underrun;

  logic            w_slot;
  logic            w_pop;
  logic            w_push;
  logic            w_full;
  logic            w_empty;
  logic [DI_W-1:0] w_head;
  logic [LW-1:0]   w_level;

  assign w_slot   = (r_state == ST_RUN) && (r_cnt == CNT_LAST);
  assign w_pop    = w_slot && !w_empty;
  assign w_push   = in_valid && !w_full;
  // Readiness depends on occupancy only, never on a pop in the same cycle.
  assign in_ready = !w_full;

  ef_sync_fifo #(
    .W     (DI_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (in_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_level     (w_level),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_sent     <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_slot) begin
        if (!w_empty) begin
          r_valid <= 1'b1;
          r_data  <= w_head;
          r_sent  <= r_sent + 16'd1;
        end else begin
          r_underrun <= 1'b1;
        end
      end

      if (!enable) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_PRIME;
            r_cnt   <= '0;
          end
          ST_PRIME: begin
            if (w_level >= PRIME_LEVEL) begin
              r_state <= ST_RUN;
            end
            r_cnt <= '0;
          end
          ST_RUN: begin
            r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
          end
          default: begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign valid_o  = r_valid;
  assign data_o   = r_data;
  assign level    = w_level;
  assign sent_cnt = r_sent;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_ef_sample_feeder.sv
module tb_ef_sample_feeder;

  localparam int DI_W      = 8;
  localparam int PERIOD    = 20;
  localparam int DEPTH     = 16;
  localparam int PRIME_LVL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        valid_o;
  logic [7:0]  data_o;
  logic [4:0]  level;
  logic [15:0] sent_cnt;
  logic        underrun;

  ef_sample_feeder #(
    .DI_W      (DI_W),
    .PERIOD    (PERIOD),
    .DEPTH     (DEPTH),
    .PRIME_LVL (PRIME_LVL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .valid_o  (valid_o),
    .data_o   (data_o),
    .level    (level),
    .sent_cnt (sent_cnt),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         strobes = 0;
  int         model_sent = 0;
  bit         strobe_seen = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the edge; every strobe is
  // checked against the scoreboard head and the model sample count.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    strobe_seen = 0;
    if (valid_o === 1'b1) begin
      strobe_seen = 1;
      strobes++;
      chk("strobe_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        model_sent++;
        chk("strobe_data", 32'(data_o), 32'(exp_q.pop_front()));
        chk("strobe_sent_cnt", 32'(sent_cnt), 32'(model_sent));
      end
    end
  endtask

  task automatic tick_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic wait_strobe(input int budget, input string tag);
    bit got;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (strobe_seen) begin
        got = 1;
        break;
      end
    end
    chk({tag, "_timeout"}, 32'(got), 1);
  endtask

  task automatic push(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    exp_q.push_back(d);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    model_sent = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, s, r0, p, n0, prev;
    logic [7:0] v;

    rst = 1'b1; enable = 1'b0; in_valid = 1'b0; in_data = '0;
    tick();
    do_reset();
    chk("rst_valid_o", 32'(valid_o), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_sent_cnt", 32'(sent_cnt), 0);
    chk("rst_underrun", 32'(underrun), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_data_o", 32'(data_o), 0);

    // Preload four samples while idle, then enable: PRIME, RUN, strobes.
    push(8'h20); push(8'hE3); push(8'h01); push(8'h17);
    chk("t033_level", 32'(level), 4);
    enable = 1'b1;
    c0 = cyc;
    for (int k = 1; k <= 4; k++) begin
      wait_strobe(30, "t033_wait");
      chk("t033_strobe_cyc", 32'(cyc), 32'(c0 + 2 + PERIOD * k));
    end
    chk("t033_sent_cnt", 32'(sent_cnt), 4);
    chk("t035_no_underrun_yet", 32'(underrun), 0);

    // Drained: the next slot is empty.
    n0 = strobes;
    tick_until(c0 + 2 + PERIOD * 5);
    chk("t035_no_strobe", 32'(strobes), 32'(n0));
    chk("t035_underrun", 32'(underrun), 1);
    chk("t035_data_hold", 32'(data_o), 32'h17);
    push(8'h55);
    wait_strobe(30, "t035_refill");
    chk("t035_refill_cyc", 32'(cyc), 32'(c0 + 2 + PERIOD * 6));
    chk("t035_underrun_sticky", 32'(underrun), 1);

    // Drop enable mid-slot (cnt=10), then re-enable.
    s = cyc;
    push(8'h7A); push(8'h81); push(8'h3C); push(8'hC5);
    tick_until(s + 10);
    enable = 1'b0;
    n0 = strobes;
    for (int i = 0; i < 30; i++) tick();
    chk("t037_no_strobe", 32'(strobes), 32'(n0));
    chk("t037_level", 32'(level), 4);
    chk("t037_data_hold", 32'(data_o), 32'h55);
    chk("t037_sent_hold", 32'(sent_cnt), 5);
    enable = 1'b1;
    r0 = cyc;
    wait_strobe(40, "t037_wait");
    chk("t037_strobe_cyc", 32'(cyc), 32'(r0 + 2 + PERIOD));

    // Priming threshold.
    enable = 1'b0;
    do_reset();
    chk("t034_rst_underrun", 32'(underrun), 0);
    chk("t034_rst_level", 32'(level), 0);
    enable = 1'b1;
    push(8'h11); push(8'h22);
    n0 = strobes;
    for (int i = 0; i < 30; i++) tick();
    chk("t034_no_strobe", 32'(strobes), 32'(n0));
    chk("t034_level2", 32'(level), 2);
    push(8'h33); push(8'h44);
    p = cyc;
    chk("t034_level4", 32'(level), 4);
    wait_strobe(40, "t034_wait");
    chk("t034_strobe_cyc", 32'(cyc), 32'(p + 1 + PERIOD));

    // Reset asserted on the slot-edge cycle.
    tick_until(p + 1 + 2 * PERIOD - 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    model_sent = 0;
    enable = 1'b0;
    chk("t038_valid_o", 32'(valid_o), 0);
    chk("t038_level", 32'(level), 0);
    chk("t038_sent_cnt", 32'(sent_cnt), 0);
    chk("t038_underrun", 32'(underrun), 0);

    // Fill to DEPTH while idle; full refuses the next offer.
    for (int i = 0; i < DEPTH; i++) begin
      v = 8'(i * 17 + 5);
      push(v);
    end
    chk("t036_level_full", 32'(level), 16);
    chk("t036_in_ready_full", 32'(in_ready), 0);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    tick();
    in_valid = 1'b0;
    chk("t036_17th_rejected", 32'(level), 16);
    enable = 1'b1;
    r0 = cyc;
    wait_strobe(40, "t036_wait");
    chk("t036_strobe_cyc", 32'(cyc), 32'(r0 + 2 + PERIOD));
    chk("t036_level_after_pop", 32'(level), 15);
    chk("t036_in_ready", 32'(in_ready), 1);
    // Push coincident with the next slot pop: occupancy unchanged, order kept.
    tick_until(r0 + 2 + 2 * PERIOD - 1);
    in_valid = 1'b1;
    in_data  = 8'hBB;
    exp_q.push_back(8'hBB);
    tick();
    in_valid = 1'b0;
    chk("t036_pushpop_strobe", 32'(strobe_seen), 1);
    chk("t036_pushpop_level", 32'(level), 15);
    for (int k = 0; k < 15; k++) begin
      prev = cyc;
      wait_strobe(30, "t036_drain");
      chk("t036_spacing", 32'(cyc - prev), 32'(PERIOD));
    end
    chk("t036_q_empty", 32'(exp_q.size()), 0);
    chk("t036_sent_cnt", 32'(sent_cnt), 17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
